uart_tx_fifo: RTL and testbench

- Transmit-side UART that drives the cpu's serial output pin `uart`.
- Sits directly upstream of that pin, inside `cpu`.
- The CPU's store unit writes bytes (MMIO store) into a small FIFO; the block serialises them as 8N1 frames at a fixed clocks-per-bit rate.
- Lets the CPU issue back-to-back stores without stalling for every bit time.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit UART with a small byte FIFO: MMIO stores are queued and sent as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       drop,
   output logic       uart
);

   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

   state_e          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            drop_q;
   logic            uart_q, uart_d;
   logic            push, pop, bit_end;

   // full is decoded from the registered count, so a pop never frees a slot in the same cycle
   assign full    = (count_q == DEPTH_C);
   assign push    = wr_en && !full;
   assign busy    = (count_q != '0) || (state_q != IDLE);
   assign drop    = drop_q;
   assign uart    = uart_q;
   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
         uart_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
         wr_ptr_q <= wr_ptr_q + PW'(push);
         rd_ptr_q <= rd_ptr_q + PW'(pop);
         count_q  <= count_q + CW'(push) - CW'(pop);
         drop_q   <= wr_en && full;
         uart_q   <= uart_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               shift_d  = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
               parity_d = ^mem[rd_ptr_q];
`endif
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so the pin comes straight from a flop
   always_comb begin
      uart_d = 1'b1;
      case (state_d)
         IDLE:   uart_d = 1'b1;
         START:  uart_d = 1'b0;
         DATA:   uart_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY: uart_d = parity_d;
`endif
         STOP:   uart_d = 1'b1;
         default: uart_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-and-timer reference model plus a serial-line decoder scoreboard.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       full, busy, drop, uart;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .busy(busy), .drop(drop), .uart(uart)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   byte unsigned mq[$];
   byte unsigned exp_q[$];
   int           exp_t[$];
   int           cyc = 0;
   int           tx_rem = 0;
   int           rst_epoch = 0;
   logic         fm;
   logic         exp_full = 1'b0, exp_busy = 1'b0, exp_drop = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: FIFO as a queue, transmitter as a countdown of frame cycles
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            mq.delete();
            exp_q.delete();
            exp_t.delete();
            tx_rem = 0;
            rst_epoch++;
            exp_drop = 1'b0;
         end else begin
            fm = (mq.size() == DEPTH);
            if (tx_rem == 0 && mq.size() > 0) begin
               void'(mq.pop_front());
               exp_t.push_back(cyc);
               tx_rem = FB * CPB;
            end else if (tx_rem > 0) begin
               tx_rem--;
            end
            exp_drop = wr_en && fm;
            if (wr_en && !fm) begin
               mq.push_back(wr_data);
               exp_q.push_back(wr_data);
            end
         end
         exp_full = (mq.size() == DEPTH);
         exp_busy = (mq.size() > 0) || (tx_rem > 0);
      end
   end

   // Monitor: flag checks every cycle and a mid-bit sampling frame decoder
   logic       mon_act = 1'b0;
   int         mon_s = 0, mon_epoch = 0, off, k;
   logic [7:0] mdata = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            if (rst_epoch != mon_epoch) begin
               mon_act   = 1'b0;
               mon_epoch = rst_epoch;
            end
            chk("full", int'(full), int'(exp_full));
            chk("busy", int'(busy), int'(exp_busy));
            chk("drop", int'(drop), int'(exp_drop));
            if (tx_rem == 0) chk("uart_idle", int'(uart), 1);
            if (!mon_act) begin
               if (uart == 1'b0) begin
                  mon_act = 1'b1;
                  mon_s   = cyc;
                  if (exp_t.size() == 0) chk("start_pending", exp_t.size(), 1);
                  else chk("start_time", cyc, exp_t.pop_front());
               end
            end else begin
               off = cyc - mon_s;
               if (off % CPB == CPB / 2) begin
                  k = off / CPB;
                  if (k == 0) begin
                     chk("start_bit", int'(uart), 0);
                  end else if (k <= 8) begin
                     mdata = {uart, mdata[7:1]};
`ifdef UART_TX_PARITY_EN
                  end else if (k == 9) begin
                     chk("parity_bit", int'(uart), int'(^mdata));
`endif
                  end else begin
                     chk("stop_bit", int'(uart), 1);
                     if (exp_q.size() == 0) chk("byte_pending", exp_q.size(), 1);
                     else chk("data", int'(mdata), int'(exp_q.pop_front()));
                     mon_act = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || mq.size() != 0 || tx_rem != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_in_time", int'(t < 3000), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int t;
      int cnt;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("rst_uart", int'(uart), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_drop", int'(drop), 0);

      wr(8'h55);
      drain();

      for (int i = 1; i <= 6; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      drain();

      // Saturate the FIFO so writes land on the same cycles as pops
      for (int i = 0; i < 120; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
         @(negedge clk);
      end
      wr_en = 1'b0;
      drain();

      wr(8'hA3);
      wr(8'hB1);
      wr(8'hC2);
      t = 0;
      while (uart != 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_start_seen", int'(t < 100), 1);
      repeat (17) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_uart", int'(uart), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_full", int'(full), 0);
      repeat (60) @(negedge clk);
      wr(8'h7E);
      drain();

      cnt = 0;
      t   = 0;
      while (cnt < 20 && t < 5000) begin
         if (!full && $urandom_range(0, 3) != 0) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            cnt++;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      wr_en = 1'b0;
      chk("stream_issued", cnt, 20);
      drain();

      wr(8'h07);
      wr(8'h03);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
